// File: rtl/fusion_pkg.sv
// Shared widths and the output-holding state for the fusion accumulator.
package fusion_pkg;

    localparam int IN_W_DEF  = 16;
    localparam int ACC_W_DEF = 32;
    localparam int CNT_W_DEF = 8;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_e;

endpackage

// File: rtl/fusion_sum4.sv
// Combinational extend-and-add of the four fusion-subunit sums of one beat.
module fusion_sum4
    import fusion_pkg::*;
#(
    parameter int IN_W = IN_W_DEF
) (
    input  logic [IN_W-1:0] sum0_i,
    input  logic [IN_W-1:0] sum1_i,
    input  logic [IN_W-1:0] sum2_i,
    input  logic [IN_W-1:0] sum3_i,
    input  logic            sign_i,
    output logic [IN_W+1:0] total_o
);

    logic [3:0][IN_W-1:0] sums;

    assign sums = {sum3_i, sum2_i, sum1_i, sum0_i};

    // Two guard bits are enough to hold four IN_W operands in either signedness.
    always_comb begin
        total_o = '0;
        for (int i = 0; i < 4; i++) begin
            total_o = total_o + {{2{sign_i & sums[i][IN_W-1]}}, sums[i]};
        end
    end

endmodule

// File: rtl/fusion_accum.sv
// Two-stage dot-product group accumulator: per-beat total, then a wrapping
// accumulator that hands each finished group to a held output register.
module fusion_accum
    import fusion_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_sum0,
    input  logic [IN_W-1:0]  in_sum1,
    input  logic [IN_W-1:0]  in_sum2,
    input  logic [IN_W-1:0]  in_sum3,
    input  logic             in_sign,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_beats
);

    logic             s1_valid_q;
    logic             s1_last_q;
    logic             s1_sign_q;
    logic [IN_W+1:0]  s1_total_q;
    logic [IN_W+1:0]  s1_total_d;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] out_acc_q;
    logic [CNT_W-1:0] out_beats_q;
    acc_state_e       state_q;

    logic             stall;
    logic             absorb;
    logic             absorb_last;
    logic [ACC_W-1:0] t_ext;

    fusion_sum4 #(.IN_W(IN_W)) u_sum4 (
        .sum0_i  (in_sum0),
        .sum1_i  (in_sum1),
        .sum2_i  (in_sum2),
        .sum3_i  (in_sum3),
        .sign_i  (in_sign),
        .total_o (s1_total_d)
    );

    // Only a finished group waiting behind an unconsumed result can block.
    assign stall       = s1_valid_q && s1_last_q && out_valid && !out_ready;
    assign in_ready    = !s1_valid_q || !stall;
    assign absorb      = s1_valid_q && !stall;
    assign absorb_last = absorb && s1_last_q;

    // An unsigned beat's total may use the top guard bit as magnitude, so only
    // signed beats are sign-extended into the accumulator.
    assign t_ext = {{(ACC_W-IN_W-2){s1_sign_q & s1_total_q[IN_W+1]}}, s1_total_q};
    assign acc_d = acc_q + t_ext;
    assign cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_total_q <= '0;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_last_q  <= in_last;
                s1_sign_q  <= in_sign;
                s1_total_q <= s1_total_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_acc_q   <= '0;
            out_beats_q <= '0;
        end else begin
            if (absorb_last) begin
                out_acc_q   <= acc_d;
                out_beats_q <= cnt_d;
                acc_q       <= '0;
                cnt_q       <= '0;
            end else if (absorb) begin
                acc_q <= acc_d;
                cnt_q <= cnt_d;
            end
            case (state_q)
                ACCUM: if (absorb_last) state_q <= HOLD;
                HOLD:  if (out_ready && !absorb_last) state_q <= ACCUM;
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign out_valid = (state_q == HOLD);
    assign out_acc   = out_acc_q;
    assign out_beats = out_beats_q;

endmodule
